// File: rtl/core_hcu_fwd.sv
// Hazard control unit with per-read-port operand forwarding for the 5-stage RV32I pipe.
// Optional saturating perf counters are built only when HCU_PERF_CNT_EN is defined.
module core_hcu_fwd #(
  parameter int REG_AW     = 5,
  parameter int NUM_RPORTS = 2,
  parameter int CNT_W      = 32
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_RPORTS*REG_AW-1:0] i_reg_araddr,
  input  logic [NUM_RPORTS-1:0]        i_reg_arvalid,
  input  logic [REG_AW-1:0]            i_idex_reg_awaddr,
  input  logic                         i_idex_reg_awvalid,
  input  logic [REG_AW-1:0]            i_exmem_reg_awaddr,
  input  logic                         i_exmem_reg_awvalid,
  input  logic                         i_exmem_memread,
  input  logic [REG_AW-1:0]            i_memwb_reg_awaddr,
  input  logic                         i_memwb_reg_awvalid,
  input  logic                         i_c_take_branch,
  input  logic                         i_isjal,
  input  logic                         i_isjalr,
  input  logic                         i_hcu_mem_busy,
  input  logic                         i_hcu_imem_done,
  output logic                         o_hcu_pc_write,
  output logic                         o_hcu_ifid_enable,
  output logic                         o_hcu_ifid_flush,
  output logic                         o_hcu_idex_enable,
  output logic                         o_hcu_idex_flush,
  output logic                         o_hcu_exmem_enable,
  output logic                         o_hcu_exmem_flush,
  output logic                         o_hcu_memwb_enable,
  output logic [2*NUM_RPORTS-1:0]      o_hcu_fwd_sel,
  output logic [CNT_W-1:0]             o_hcu_perf_stall,
  output logic [CNT_W-1:0]             o_hcu_perf_flush,
  output logic [CNT_W-1:0]             o_hcu_perf_memwait
);

  typedef enum logic {S_RUN, S_DROP} state_t;

  state_t r_state, w_state_nxt;
  logic   r_pend, w_pend_nxt;

  logic [NUM_RPORTS-1:0]   w_m_idex, w_m_exmem, w_m_memwb;
  logic [2*NUM_RPORTS-1:0] w_fwd;

  // x0 and non-reading ports never match any producer
  for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_port
    logic [REG_AW-1:0] w_a;
    logic              w_rd;
    assign w_a  = i_reg_araddr[p*REG_AW +: REG_AW];
    assign w_rd = i_reg_arvalid[p] && (w_a != '0);
    assign w_m_idex[p]  = w_rd && i_idex_reg_awvalid  && (w_a == i_idex_reg_awaddr);
    assign w_m_exmem[p] = w_rd && i_exmem_reg_awvalid && (w_a == i_exmem_reg_awaddr);
    assign w_m_memwb[p] = w_rd && i_memwb_reg_awvalid && (w_a == i_memwb_reg_awaddr);
    assign w_fwd[2*p +: 2] = (w_m_exmem[p] && !i_exmem_memread) ? 2'b01 :
                             w_m_memwb[p]                       ? 2'b10 : 2'b00;
  end

  logic w_raw_redir, w_ctrl, w_data;
  assign w_raw_redir = i_c_take_branch | i_isjal | i_isjalr;
  assign w_ctrl      = w_raw_redir | r_pend;
  assign w_data      = |(w_m_idex | (w_m_exmem & {NUM_RPORTS{i_exmem_memread}}));

  assign o_hcu_fwd_sel = i_rst ? '0 : w_fwd;

  always_comb begin
    o_hcu_pc_write     = 1'b1;
    o_hcu_ifid_enable  = 1'b1;
    o_hcu_ifid_flush   = 1'b0;
    o_hcu_idex_enable  = 1'b1;
    o_hcu_idex_flush   = 1'b0;
    o_hcu_exmem_enable = 1'b1;
    o_hcu_exmem_flush  = 1'b0;
    o_hcu_memwb_enable = 1'b1;
    w_state_nxt        = r_state;
    w_pend_nxt         = r_pend;
    if (i_rst) begin
      o_hcu_pc_write     = 1'b0;
      o_hcu_ifid_enable  = 1'b0;
      o_hcu_idex_enable  = 1'b0;
      o_hcu_exmem_enable = 1'b0;
      o_hcu_memwb_enable = 1'b0;
      o_hcu_ifid_flush   = 1'b1;
      o_hcu_idex_flush   = 1'b1;
      o_hcu_exmem_flush  = 1'b1;
      w_state_nxt        = S_RUN;
      w_pend_nxt         = 1'b0;
    end else if (i_hcu_mem_busy) begin
      // freeze: a redirect seen now is replayed on the first non-busy cycle
      o_hcu_pc_write     = 1'b0;
      o_hcu_ifid_enable  = 1'b0;
      o_hcu_idex_enable  = 1'b0;
      o_hcu_exmem_enable = 1'b0;
      o_hcu_memwb_enable = 1'b0;
      if (w_raw_redir) w_pend_nxt = 1'b1;
    end else if (w_ctrl) begin
      o_hcu_ifid_flush = 1'b1;
      o_hcu_idex_flush = 1'b1;
      w_pend_nxt       = 1'b0;
      w_state_nxt      = i_hcu_imem_done ? S_RUN : S_DROP;
    end else if (r_state == S_DROP) begin
      // the fetch in flight at the redirect is stale; squash it when it lands
      o_hcu_pc_write   = 1'b0;
      o_hcu_ifid_flush = 1'b1;
      if (i_hcu_imem_done) w_state_nxt = S_RUN;
    end else if (w_data) begin
      o_hcu_pc_write    = 1'b0;
      o_hcu_ifid_enable = 1'b0;
      o_hcu_idex_flush  = 1'b1;
    end else if (!i_hcu_imem_done) begin
      o_hcu_pc_write   = 1'b0;
      o_hcu_ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_RUN;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

`ifdef HCU_PERF_CNT_EN
  logic [CNT_W-1:0] r_cnt_stall, r_cnt_flush, r_cnt_memwait;
  logic w_ev_stall, w_ev_flush, w_ev_memwait;
  assign w_ev_memwait = i_hcu_mem_busy;
  assign w_ev_flush   = !i_hcu_mem_busy && w_ctrl;
  assign w_ev_stall   = !i_hcu_mem_busy && !w_ctrl && (r_state == S_RUN) && w_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt_stall   <= '0;
      r_cnt_flush   <= '0;
      r_cnt_memwait <= '0;
    end else begin
      if (w_ev_stall   && r_cnt_stall   != '1) r_cnt_stall   <= r_cnt_stall   + CNT_W'(1);
      if (w_ev_flush   && r_cnt_flush   != '1) r_cnt_flush   <= r_cnt_flush   + CNT_W'(1);
      if (w_ev_memwait && r_cnt_memwait != '1) r_cnt_memwait <= r_cnt_memwait + CNT_W'(1);
    end
  end

  assign o_hcu_perf_stall   = r_cnt_stall;
  assign o_hcu_perf_flush   = r_cnt_flush;
  assign o_hcu_perf_memwait = r_cnt_memwait;
`else
  assign o_hcu_perf_stall   = '0;
  assign o_hcu_perf_flush   = '0;
  assign o_hcu_perf_memwait = '0;
`endif

endmodule

// File: doc/core_hcu_fwd.md
Name: core_hcu_fwd

Overview:
- Second-generation hazard control unit for the RV32I pipeline (IF, ID, EX, MEM, WB).
- Adds per-read-port operand forwarding selects for the ID stage, generalised to NUM_RPORTS register read ports.
- Stalls only on true unforwardable dependencies and freezes the pipe during data-memory waits.
- Holds a control redirect pending while frozen, and discards the stale instruction fetch that was in flight at a redirect.

Parameters:
- REG_AW, 5, register index width.
- NUM_RPORTS, 2, number of register read ports checked and forwarded.
- CNT_W, 32, width of performance counters (used only with HCU_PERF_CNT_EN).

Ports:
- CLK  in  1  pipeline clock
- RST  in  1  synchronous active-high reset
- REG_ARADDR  in  NUM_RPORTS*REG_AW  ID-stage source indices, port i at bits [i*REG_AW +: REG_AW]
- REG_ARVALID  in  NUM_RPORTS  port i actually reads a source
- IDEX_REG_AWADDR / IDEX_REG_AWVALID  in  REG_AW / 1  EX-stage destination
- EXMEM_REG_AWADDR / EXMEM_REG_AWVALID / EXMEM_MEMREAD  in  REG_AW / 1 / 1  MEM-stage destination, MEM-stage instruction is a load
- MEMWB_REG_AWADDR / MEMWB_REG_AWVALID  in  REG_AW / 1  WB-stage destination
- C_TAKE_BRANCH, ISJAL, ISJALR  in  1 each  EX-stage redirect
- HCU_MEM_BUSY  in  1  data-memory access in progress
- HCU_IMEM_DONE  in  1  instruction fetch completes this cycle
- HCU_PC_WRITE, HCU_IFID_ENABLE, HCU_IFID_FLUSH, HCU_IDEX_ENABLE, HCU_IDEX_FLUSH, HCU_EXMEM_ENABLE, HCU_EXMEM_FLUSH, HCU_MEMWB_ENABLE  out  1 each  pipeline control
- HCU_FWD_SEL  out  2*NUM_RPORTS  per-port select: 00 regfile, 01 EXMEM result, 10 MEMWB writeback
- HCU_PERF_STALL, HCU_PERF_FLUSH, HCU_PERF_MEMWAIT  out  CNT_W each  counters

Behaviour:
- Registered state:
  - FSM {RUN, DROP}.
  - pend_redirect flag.
  - Counters.
  - All control outputs are combinational from state and inputs.
- Per-port match: addr != 0, ARVALID=1, AWVALID=1, equal indices. x0 never matches.
- Forwarding, per port, in priority order:
  - EXMEM match and !EXMEM_MEMREAD -> 01.
  - Else MEMWB match -> 10.
  - Else 00.
- Data hazard (any port):
  - IDEX match, or
  - EXMEM match with EXMEM_MEMREAD=1.
- Control hazard: C_TAKE_BRANCH|ISJAL|ISJALR, or pend_redirect.
- Defaults: all enables=1, PC_WRITE=1, flushes=0. EXMEM_FLUSH is always 0 outside reset.
- Priority, highest first:
  1. RST=1:
     - Enables=0, PC_WRITE=0, IFID/IDEX/EXMEM_FLUSH=1, FWD_SEL=0.
     - Next state RUN, pend_redirect=0, counters=0.
  2. HCU_MEM_BUSY=1 (freeze):
     - All enables=0, PC_WRITE=0, flushes=0.
     - A raw redirect this cycle sets pend_redirect=1.
     - State is held.
  3. Control hazard:
     - IFID_FLUSH=1, IDEX_FLUSH=1, PC_WRITE=1.
     - pend_redirect cleared next cycle.
     - If HCU_IMEM_DONE=0, next state DROP.
  4. State DROP:
     - PC_WRITE=0, IFID_FLUSH=1.
     - Later stages run normally.
     - Exit to RUN on the cycle HCU_IMEM_DONE=1. The stale instruction is flushed that cycle.
  5. Data hazard:
     - PC_WRITE=0, IFID_ENABLE=0, IDEX_FLUSH=1 (bubble).
     - EXMEM/MEMWB advance.
     - Re-evaluated every cycle: IDEX non-load dependency costs 1 cycle, load dependency costs 2.
  6. HCU_IMEM_DONE=0 in RUN: PC_WRITE=0, IFID_FLUSH=1 (bubble into ID).
- Simultaneous events:
  - Data hazard plus control hazard: control wins; the dependent instruction is flushed.
  - MEM_BUSY plus redirect: the redirect is latched and applied on the first non-busy cycle.
  - A redirect arriving while pend_redirect=1 is absorbed (single flag).
- Reset mid-DROP or mid-freeze returns to RUN with no pending redirect.

Optional Feature:
- Macro: HCU_PERF_CNT_EN.
- Defined:
  - HCU_PERF_STALL increments on each data-hazard stall cycle.
  - HCU_PERF_FLUSH increments on each cycle where priority 3 applies.
  - HCU_PERF_MEMWAIT increments on each MEM_BUSY cycle.
  - All counters are saturating at 2^CNT_W-1 and cleared by RST.
- Undefined: the three outputs are tied to 0 and no counter flops exist.

Test Plan:
- Load-use, read-after-write: IDEX_AWADDR=5, load; ID reads x5 on port 0.
  - Response: PC_WRITE=0 and IDEX_FLUSH=1 for 2 cycles as the load moves to EXMEM.
  - Then FWD_SEL[1:0]=10 with no stall.
- ALU forward: EXMEM_AWADDR=3 non-load, MEMWB_AWADDR=3, port 1 reads x3.
  - Response: FWD_SEL[3:2]=01, no stall.
  - x0 on both ports, all stages writing x0 -> FWD_SEL=0000, no stall.
- Redirect during freeze: MEM_BUSY=1 for 3 cycles, ISJAL=1 in cycle 1.
  - Response: all enables=0 for 3 cycles.
  - On cycle 4, IFID_FLUSH=IDEX_FLUSH=1 and PC_WRITE=1.
  - Cycle 5: no flush.
- Stale fetch drop: C_TAKE_BRANCH=1 with IMEM_DONE=0, then IMEM_DONE=1 two cycles later.
  - Response: IFID_FLUSH=1 for 3 cycles, PC_WRITE=0 in DROP.
  - Back to RUN afterwards.
- Priority: data hazard and ISJALR in the same cycle.
  - Response: IFID_FLUSH=1, IDEX_FLUSH=1, PC_WRITE=1.
- Reset during DROP: RST=1 for 1 cycle.
  - Response: flushes=1, enables=0.
  - Next cycle in RUN with defaults.
  - Perf counters read 0 (HCU_PERF_CNT_EN defined).
